// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_arbiter
//  Purpose  : Round-robin arbiter that shares one logic unit among NUM_REQ
//             requesters, with a response handshake and a WAIT-state timeout.
//  Revision : 1.0  initial release
// ============================================================================
module logic_unit_arbiter #(
   parameter int inWidth  = 7,
   parameter int outWidth = 15,
   parameter int NUM_REQ  = 4
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [NUM_REQ-1:0]           Req_Valid,
   input  logic [NUM_REQ*(inWidth+1)-1:0] Req_A,
   input  logic [NUM_REQ*(inWidth+1)-1:0] Req_B,
   input  logic [NUM_REQ*2-1:0]         Req_FUN,
   output logic [NUM_REQ-1:0]           Req_Ready,
   output logic [NUM_REQ-1:0]           Resp_Valid,
   input  logic [NUM_REQ-1:0]           Resp_Ready,
   output logic [outWidth:0]            Resp_Data,
   output logic                         Resp_Err,
   output logic [inWidth:0]             LU_A,
   output logic [inWidth:0]             LU_B,
   output logic [1:0]                   LU_FUN,
   output logic                         LU_Enable,
   input  logic [outWidth:0]            LU_OUT,
   input  logic                         LU_Flag,
   output logic                         Busy
);

   localparam int             c_PW      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam logic [c_PW-1:0] c_LAST   = c_PW'(NUM_REQ - 1);
   localparam logic [c_PW-1:0] c_ONE    = c_PW'(1);
   localparam logic [2:0]     c_TO_LAST = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              r_state, w_state;
   logic [c_PW-1:0]     r_ptr, w_ptr;
   logic [c_PW-1:0]     r_gnt, w_gnt_q;
   logic [inWidth:0]    r_a, w_a;
   logic [inWidth:0]    r_b, w_b;
   logic [1:0]          r_fun, w_fun;
   logic [2:0]          r_cnt, w_cnt;

   logic [NUM_REQ-1:0]  w_req_ready;
   logic [NUM_REQ-1:0]  w_resp_valid;
   logic [outWidth:0]   w_resp_data;
   logic                w_resp_err;
   logic [inWidth:0]    w_lu_a, w_lu_b;
   logic [1:0]          w_lu_fun;
   logic                w_lu_en;
   logic                w_busy;

   logic [c_PW-1:0]     w_hi, w_lo, w_gnt;
   logic                w_hi_found;

   // Rotating priority: lowest valid index at or above the pointer wins,
   // otherwise wrap around to the lowest valid index overall.
   always_comb begin
      w_hi       = '0;
      w_lo       = '0;
      w_hi_found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (Req_Valid[i]) begin
            w_lo = c_PW'(i);
            if (i >= int'(r_ptr)) begin
               w_hi       = c_PW'(i);
               w_hi_found = 1'b1;
            end
         end
      end
      w_gnt = w_hi_found ? w_hi : w_lo;
   end

   always_comb begin
      w_state      = r_state;
      w_ptr        = r_ptr;
      w_gnt_q      = r_gnt;
      w_a          = r_a;
      w_b          = r_b;
      w_fun        = r_fun;
      w_cnt        = r_cnt;
      w_req_ready  = '0;
      w_resp_valid = Resp_Valid;
      w_resp_data  = Resp_Data;
      w_resp_err   = Resp_Err;
      w_lu_a       = LU_A;
      w_lu_b       = LU_B;
      w_lu_fun     = LU_FUN;
      w_lu_en      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (|Req_Valid) begin
               w_req_ready[w_gnt] = 1'b1;
               w_gnt_q = w_gnt;
               w_a     = Req_A[w_gnt*(inWidth+1) +: (inWidth+1)];
               w_b     = Req_B[w_gnt*(inWidth+1) +: (inWidth+1)];
               w_fun   = Req_FUN[w_gnt*2 +: 2];
               w_state = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_lu_a   = r_a;
            w_lu_b   = r_b;
            w_lu_fun = r_fun;
            w_lu_en  = 1'b1;
            w_cnt    = '0;
            w_state  = S_WAIT;
         end
         S_WAIT: begin
            if (LU_Flag) begin
               w_resp_valid        = '0;
               w_resp_valid[r_gnt] = 1'b1;
               w_resp_data         = LU_OUT;
               w_resp_err          = 1'b0;
               w_lu_a              = '0;
               w_lu_b              = '0;
               w_lu_fun            = '0;
               w_state             = S_RESP;
            end else if (r_cnt == c_TO_LAST) begin
               w_cnt               = r_cnt + 3'd1;
               w_resp_valid        = '0;
               w_resp_valid[r_gnt] = 1'b1;
               w_resp_data         = '0;
               w_resp_err          = 1'b1;
               w_lu_a              = '0;
               w_lu_b              = '0;
               w_lu_fun            = '0;
               w_state             = S_RESP;
            end else begin
               w_cnt = r_cnt + 3'd1;
            end
         end
         S_RESP: begin
            if (Resp_Ready[r_gnt]) begin
               w_resp_valid = '0;
               w_ptr        = (r_gnt == c_LAST) ? '0 : (r_gnt + c_ONE);
               w_state      = S_IDLE;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      w_busy = (w_state != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_gnt      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_fun      <= '0;
         r_cnt      <= '0;
         Req_Ready  <= '0;
         Resp_Valid <= '0;
         Resp_Data  <= '0;
         Resp_Err   <= 1'b0;
         LU_A       <= '0;
         LU_B       <= '0;
         LU_FUN     <= '0;
         LU_Enable  <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_ptr      <= w_ptr;
         r_gnt      <= w_gnt_q;
         r_a        <= w_a;
         r_b        <= w_b;
         r_fun      <= w_fun;
         r_cnt      <= w_cnt;
         Req_Ready  <= w_req_ready;
         Resp_Valid <= w_resp_valid;
         Resp_Data  <= w_resp_data;
         Resp_Err   <= w_resp_err;
         LU_A       <= w_lu_a;
         LU_B       <= w_lu_b;
         LU_FUN     <= w_lu_fun;
         LU_Enable  <= w_lu_en;
         Busy       <= w_busy;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_arbiter
//  Purpose  : Directed self-checking bench for logic_unit_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_unit_arbiter;

   localparam int c_N = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic [3:0]    Req_Valid;
   logic [31:0]   Req_A, Req_B;
   logic [7:0]    Req_FUN;
   logic [3:0]    Req_Ready, Resp_Valid, Resp_Ready;
   logic [15:0]   Resp_Data;
   logic          Resp_Err;
   logic [7:0]    LU_A, LU_B;
   logic [1:0]    LU_FUN;
   logic          LU_Enable;
   logic [15:0]   LU_OUT;
   logic          LU_Flag;
   logic          Busy;
   logic          lu_dead = 1'b0;

   int n_cmp = 0;
   int n_mis = 0;

   logic_unit_arbiter #(.inWidth(7), .outWidth(15), .NUM_REQ(c_N)) u_dut (
      .CLK(CLK), .RST(RST),
      .Req_Valid(Req_Valid), .Req_A(Req_A), .Req_B(Req_B), .Req_FUN(Req_FUN),
      .Req_Ready(Req_Ready), .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready),
      .Resp_Data(Resp_Data), .Resp_Err(Resp_Err),
      .LU_A(LU_A), .LU_B(LU_B), .LU_FUN(LU_FUN), .LU_Enable(LU_Enable),
      .LU_OUT(LU_OUT), .LU_Flag(LU_Flag), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] lu_op(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] f);
      logic [7:0] r;
      case (f)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         default: r = ~a;
      endcase
      return {8'h00, r};
   endfunction

   // Logic unit stand-in: answers one cycle after enable unless stuck.
   always @(posedge CLK) begin
      LU_Flag <= LU_Enable && !lu_dead;
      LU_OUT  <= lu_op(LU_A, LU_B, LU_FUN);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] f);
      Req_A[i*8 +: 8]   = a;
      Req_B[i*8 +: 8]   = b;
      Req_FUN[i*2 +: 2] = f;
   endtask

   task automatic wait_grant(input string tag, input int exp_g);
      int g;
      g = -1;
      for (int c = 0; c < 40 && g < 0; c++) begin
         @(negedge CLK);
         for (int i = 0; i < c_N; i++) if (Req_Ready[i]) g = i;
      end
      chk(tag, g, exp_g);
      if (g >= 0) chk({tag, "_onehot"}, {28'd0, Req_Ready}, 32'd1 << exp_g);
   endtask

   task automatic wait_resp(input string tag, input logic [3:0] vec,
                            input logic [15:0] data, input logic err);
      for (int c = 0; c < 40 && Resp_Valid == 4'd0; c++) @(negedge CLK);
      chk({tag, "_vec"},  {28'd0, Resp_Valid}, {28'd0, vec});
      chk({tag, "_data"}, {16'd0, Resp_Data},  {16'd0, data});
      chk({tag, "_err"},  {31'd0, Resp_Err},   {31'd0, err});
   endtask

   task automatic do_reset();
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b0; Req_Valid = '0; Req_A = '0; Req_B = '0; Req_FUN = '0;
      Resp_Ready = '0;
      repeat (3) @(negedge CLK);
      chk("rst_req_ready",  {28'd0, Req_Ready},  32'd0);
      chk("rst_resp_valid", {28'd0, Resp_Valid}, 32'd0);
      chk("rst_resp_data",  {16'd0, Resp_Data},  32'd0);
      chk("rst_lu_en",      {31'd0, LU_Enable},  32'd0);
      chk("rst_busy",       {31'd0, Busy},       32'd0);
      RST = 1'b1;

      // Single AND with exact latency
      set_op(0, 8'hF0, 8'h3C, 2'b00);
      Req_Valid = 4'b0001;
      wait_grant("and_grant", 0);
      Req_Valid = 4'b0000;
      chk("and_busy_T", {31'd0, Busy}, 32'd1);
      chk("and_en_T",   {31'd0, LU_Enable}, 32'd0);
      @(negedge CLK);
      chk("and_en_T1",  {31'd0, LU_Enable}, 32'd1);
      chk("and_lu_a",   {24'd0, LU_A}, 32'h0F0);
      chk("and_lu_b",   {24'd0, LU_B}, 32'h03C);
      chk("and_lu_fun", {30'd0, LU_FUN}, 32'd0);
      @(negedge CLK);
      chk("and_en_T2",  {31'd0, LU_Enable}, 32'd0);
      chk("and_rv_T2",  {28'd0, Resp_Valid}, 32'd0);
      chk("and_hold_a", {24'd0, LU_A}, 32'h0F0);
      @(negedge CLK);
      chk("and_rv_T3",  {28'd0, Resp_Valid}, 32'd1);
      chk("and_data",   {16'd0, Resp_Data}, 32'h0030);
      chk("and_err",    {31'd0, Resp_Err}, 32'd0);
      Resp_Ready = 4'b0001;
      @(negedge CLK);
      chk("and_rv_done", {28'd0, Resp_Valid}, 32'd0);
      chk("and_idle",    {31'd0, Busy}, 32'd0);

      // Round robin with all requesters active
      do_reset();
      set_op(0, 8'h12, 8'h34, 2'b10);
      set_op(1, 8'h55, 8'hAA, 2'b10);
      set_op(2, 8'hF0, 8'hF0, 2'b10);
      set_op(3, 8'h81, 8'h01, 2'b10);
      Resp_Ready = 4'b1111;
      Req_Valid  = 4'b1111;
      wait_grant("rr_g0", 0); wait_resp("rr_r0", 4'b0001, 16'h0026, 1'b0);
      wait_grant("rr_g1", 1); wait_resp("rr_r1", 4'b0010, 16'h00FF, 1'b0);
      wait_grant("rr_g2", 2); wait_resp("rr_r2", 4'b0100, 16'h0000, 1'b0);
      wait_grant("rr_g3", 3); wait_resp("rr_r3", 4'b1000, 16'h0080, 1'b0);
      wait_grant("rr_g4", 0);
      Req_Valid = 4'b0000;
      wait_resp("rr_r4", 4'b0001, 16'h0026, 1'b0);

      // Pointer skip (pointer is at 1)
      Req_Valid = 4'b0010; wait_grant("skip_g1", 1); Req_Valid = 4'b0000;
      wait_resp("skip_r1", 4'b0010, 16'h00FF, 1'b0);
      Req_Valid = 4'b0001; wait_grant("skip_g0", 0); Req_Valid = 4'b0000;
      wait_resp("skip_r0", 4'b0001, 16'h0026, 1'b0);
      Req_Valid = 4'b1001; wait_grant("skip_g3", 3); Req_Valid = 4'b0000;
      wait_resp("skip_r3", 4'b1000, 16'h0080, 1'b0);

      // Timeout with a stuck logic unit (pointer is at 0)
      lu_dead   = 1'b1;
      Req_Valid = 4'b0001;
      wait_grant("to_grant", 0);
      Req_Valid = 4'b0000;
      repeat (7) @(negedge CLK);
      chk("to_rv_T7",   {28'd0, Resp_Valid}, 32'd0);
      chk("to_busy_T7", {31'd0, Busy}, 32'd1);
      @(negedge CLK);
      chk("to_rv_T8",   {28'd0, Resp_Valid}, 32'd1);
      chk("to_data",    {16'd0, Resp_Data}, 32'd0);
      chk("to_err",     {31'd0, Resp_Err}, 32'd1);
      @(negedge CLK);
      lu_dead = 1'b0;

      // Response stall; non-granted Resp_Ready must be ignored
      set_op(1, 8'h0F, 8'hA0, 2'b01);
      Resp_Ready = 4'b0000;
      Req_Valid  = 4'b0110;
      wait_grant("st_grant", 1);
      wait_resp("st_r", 4'b0010, 16'h00AF, 1'b0);
      Resp_Ready = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         chk("st_hold_rv",   {28'd0, Resp_Valid}, 32'h2);
         chk("st_hold_data", {16'd0, Resp_Data},  32'h00AF);
         chk("st_no_grant",  {28'd0, Req_Ready},  32'd0);
      end
      Resp_Ready = 4'b0010;
      @(negedge CLK);
      chk("st_rv_clear", {28'd0, Resp_Valid}, 32'd0);
      wait_grant("st_next", 2);
      Req_Valid  = 4'b0000;
      Resp_Ready = 4'b1111;
      wait_resp("st_r2", 4'b0100, 16'h0000, 1'b0);

      // Reset asserted while waiting on the logic unit
      Req_Valid = 4'b1000;
      wait_grant("rw_grant", 3);
      Req_Valid = 4'b0000;
      @(negedge CLK);
      chk("rw_en_pre", {31'd0, LU_Enable}, 32'd1);
      RST = 1'b0;
      #1;
      chk("rw_lu_en", {31'd0, LU_Enable}, 32'd0);
      chk("rw_lu_a",  {24'd0, LU_A}, 32'd0);
      chk("rw_lu_b",  {24'd0, LU_B}, 32'd0);
      chk("rw_busy",  {31'd0, Busy}, 32'd0);
      chk("rw_rv",    {28'd0, Resp_Valid}, 32'd0);
      chk("rw_rr",    {28'd0, Req_Ready}, 32'd0);
      Req_Valid = 4'b1001;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      wait_grant("rw_next", 0);
      chk("rw_no_stale", {28'd0, Resp_Valid}, 32'd0);
      Req_Valid = 4'b0000;
      wait_resp("rw_r0", 4'b0001, 16'h0026, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
